// File: rtl/img_seq_pkg.sv
// Shared types, mode constants and frame-size helper for the image address sequencer.
package img_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam logic MODE_LINEAR = 1'b0;
  localparam logic MODE_DECIM2 = 1'b1;

  // Number of output pixels produced by one frame in the given read mode.
  function automatic int unsigned nout(input logic mode, input int unsigned w, input int unsigned h);
    if (mode == MODE_DECIM2) begin
      return (w / 32'd2) * (h / 32'd2);
    end else begin
      return w * h;
    end
  endfunction

endpackage

// File: rtl/img_lat_tracker.sv
// Counts issued reads whose read-memory latency has elapsed. A read accepted in
// cycle c becomes visible in the count from cycle c+RD_LAT onward.
module img_lat_tracker #(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_push,
  output logic [CNT_W-1:0] o_vld_cnt
);

  logic             w_mature;
  logic [CNT_W-1:0] r_vld_cnt;

  generate
    if (RD_LAT == 1) begin : g_direct
      // With a single cycle of latency the accepted read matures at the same edge.
      assign w_mature = i_push;
    end else begin : g_shift
      logic [RD_LAT-2:0] r_sr;

      // Delay line of accepted reads; the oldest stage matures at the next edge.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sr <= '0;
        end else if (i_clr) begin
          r_sr <= '0;
        end else begin
          r_sr <= (r_sr << 1) | (RD_LAT-1)'(i_push);
        end
      end

      assign w_mature = r_sr[RD_LAT-2];
    end
  endgenerate

  // Running count of matured reads, restarted at the beginning of every frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_cnt <= '0;
    end else if (i_clr) begin
      r_vld_cnt <= '0;
    end else if (w_mature) begin
      r_vld_cnt <= r_vld_cnt + CNT_W'(1);
    end
  end

  assign o_vld_cnt = r_vld_cnt;

endmodule

// File: rtl/image_addr_sequencer.sv
// 2-D read/write address sequencer for the raw and processed image memories.
// Reads walk the frame linearly or with 2x decimation; writes may never get
// ahead of reads whose data has come back from the read memory.
module image_addr_sequencer
  import img_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned IMG_W  = 390,
  parameter int unsigned IMG_H  = 390,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_mode,
  input  logic [ADDR_W-1:0] i_base_rd,
  input  logic [ADDR_W-1:0] i_base_wr,
  input  logic              i_rd_adv,
  input  logic              i_wr_adv,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic              o_rd_ack,
  output logic              o_wr_ack,
  output logic              o_busy,
  output logic              o_frame_done
);

  localparam int unsigned      CNT_W      = $clog2(IMG_W * IMG_H + 1);
  localparam logic [CNT_W-1:0] C_W        = CNT_W'(IMG_W);
  localparam logic [CNT_W-1:0] C_NOUT_LIN = CNT_W'(nout(MODE_LINEAR, IMG_W, IMG_H));
  localparam logic [CNT_W-1:0] C_NOUT_DEC = CNT_W'(nout(MODE_DECIM2, IMG_W, IMG_H));
  localparam logic [CNT_W-1:0] C_ROW_LIN  = CNT_W'(IMG_W);
  localparam logic [CNT_W-1:0] C_ROW_DEC  = CNT_W'(2 * IMG_W);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_mode;
  logic [ADDR_W-1:0] r_base_rd;
  logic [ADDR_W-1:0] r_base_wr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [CNT_W-1:0]  r_col;
  logic [CNT_W-1:0]  r_row_base;
  logic [CNT_W-1:0]  r_rd_cnt;
  logic [CNT_W-1:0]  r_wr_cnt;
  logic              r_frame_done;

  logic [CNT_W-1:0]  w_vld_cnt;
  logic [CNT_W-1:0]  w_nout;
  logic [CNT_W-1:0]  w_step_c;
  logic [CNT_W-1:0]  w_step_r;
  logic [CNT_W-1:0]  w_col_sum;
  logic [CNT_W-1:0]  w_col_nxt;
  logic [CNT_W-1:0]  w_row_nxt;
  logic              w_rd_last;
  logic              w_wr_last;
  logic              w_wr_open;
  logic              w_load;
  logic              w_rd_ack;
  logic              w_wr_ack;
  logic              w_done;

  // Frame size, traversal steps and the next read position after an accepted read.
  always_comb begin
    w_nout    = C_NOUT_LIN;
    w_step_c  = CNT_W'(1);
    w_step_r  = C_ROW_LIN;
    w_col_nxt = r_col;
    w_row_nxt = r_row_base;
    if (r_mode == MODE_DECIM2) begin
      w_nout   = C_NOUT_DEC;
      w_step_c = CNT_W'(2);
      w_step_r = C_ROW_DEC;
    end else begin
      w_nout   = C_NOUT_LIN;
      w_step_c = CNT_W'(1);
      w_step_r = C_ROW_LIN;
    end
    w_col_sum = r_col + w_step_c;
    if (w_col_sum >= C_W) begin
      w_col_nxt = '0;
      w_row_nxt = r_row_base + w_step_r;
    end else begin
      w_col_nxt = w_col_sum;
      w_row_nxt = r_row_base;
    end
  end

  assign w_rd_last = ((r_rd_cnt + CNT_W'(1)) == w_nout);
  assign w_wr_last = ((r_wr_cnt + CNT_W'(1)) == w_nout);
  // Compares against the matured count before this cycle's read is added.
  assign w_wr_open = (r_wr_cnt < w_vld_cnt);

  // Next-state and handshake decode; abort overrides every request while busy.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_rd_ack    = 1'b0;
    w_wr_ack    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_rd_ack = i_rd_adv;
          w_wr_ack = i_wr_adv && w_wr_open;
          if (w_rd_ack && w_rd_last) begin
            w_state_nxt = S_DRAIN;
          end else begin
            w_state_nxt = S_RUN;
          end
        end
      end
      S_DRAIN: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_wr_ack = i_wr_adv && w_wr_open;
          if (w_wr_ack && w_wr_last) begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Frame parameters, traversal counters and registered address outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode     <= MODE_LINEAR;
      r_base_rd  <= '0;
      r_base_wr  <= '0;
      r_col      <= '0;
      r_row_base <= '0;
      r_rd_cnt   <= '0;
      r_wr_cnt   <= '0;
      r_rd_addr  <= '0;
      r_wr_addr  <= '0;
    end else if (w_load) begin
      r_mode     <= i_mode;
      r_base_rd  <= i_base_rd;
      r_base_wr  <= i_base_wr;
      r_col      <= '0;
      r_row_base <= '0;
      r_rd_cnt   <= '0;
      r_wr_cnt   <= '0;
      r_rd_addr  <= i_base_rd;
      r_wr_addr  <= i_base_wr;
    end else begin
      if (w_rd_ack) begin
        r_rd_cnt   <= r_rd_cnt + CNT_W'(1);
        r_col      <= w_col_nxt;
        r_row_base <= w_row_nxt;
        r_rd_addr  <= r_base_rd + ADDR_W'(w_row_nxt) + ADDR_W'(w_col_nxt);
      end
      if (w_wr_ack) begin
        r_wr_cnt  <= r_wr_cnt + CNT_W'(1);
        r_wr_addr <= r_base_wr + ADDR_W'(r_wr_cnt + CNT_W'(1));
      end
    end
  end

  // One-cycle completion pulse following the final accepted write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_done;
    end
  end

  img_lat_tracker #(
    .RD_LAT (RD_LAT),
    .CNT_W  (CNT_W)
  ) u_lat (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_load),
    .i_push    (w_rd_ack),
    .o_vld_cnt (w_vld_cnt)
  );

  assign o_rd_addr    = r_rd_addr;
  assign o_wr_addr    = r_wr_addr;
  assign o_rd_ack     = w_rd_ack;
  assign o_wr_ack     = w_wr_ack;
  assign o_busy       = (r_state != S_IDLE);
  assign o_frame_done = r_frame_done;

endmodule

// File: doc/image_addr_sequencer.md
Name: image_addr_sequencer

Overview:
- Parametrised address sequencer for the raw-image and processed-image memories.
- Generalises the single-increment address counters to full 2-D frame traversal:
  - programmable base addresses;
  - linear or 2x-decimation read mode;
  - frame-end detection;
  - write-never-overtakes-read interlock that accounts for read-memory latency.
- Sits between the control unit (which raises advance requests) and the two image memories (which take the address outputs).

Parameters:
- ADDR_W, 32, width of all address ports and the base registers.
- IMG_W, 390, frame width in pixels; must be even and >= 2.
- IMG_H, 390, frame height in pixels; must be even and >= 2.
- RD_LAT, 1, read-memory latency in cycles (1..4); a read is "valid" RD_LAT cycles after issue.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- start  in  1  begin a frame; honoured only in IDLE.
- abort  in  1  return to IDLE from any state next cycle.
- mode  in  1  0 = linear, 1 = decimate by 2; sampled on start.
- base_rd  in  ADDR_W  raw-image base address; sampled on start.
- base_wr  in  ADDR_W  processed-image base address; sampled on start.
- rd_adv  in  1  request to consume the current read address.
- wr_adv  in  1  request to consume the current write address.
- rd_addr  out  ADDR_W  current raw-image read address.
- wr_addr  out  ADDR_W  current processed-image write address.
- rd_ack  out  1  rd_adv accepted this cycle (combinational).
- wr_ack  out  1  wr_adv accepted this cycle (combinational).
- busy  out  1  state is RUN or DRAIN.
- frame_done  out  1  single-cycle pulse at frame completion.

Behaviour:
- Interface (already decided): one clock, clk; reset is rst, asynchronous and active-high.
- Reset: state=IDLE; all counters, rd_addr, wr_addr, frame_done and busy = 0.
- Constants:
  - NOUT = IMG_W*IMG_H when mode=0, (IMG_W/2)*(IMG_H/2) when mode=1.
  - STEP_C = 1 + mode; STEP_R = IMG_W*(1 + mode).
- Internal registers:
  - col, row_base, rd_cnt, wr_cnt, each clog2(IMG_W*IMG_H+1) bits;
  - vld_cnt: count of issued reads whose RD_LAT delay has elapsed, driven by an RD_LAT-deep shift register of accepted reads.
- Addresses (all arithmetic modulo 2^ADDR_W, wrap silently):
  - rd_addr = base_rd_q + row_base + col;
  - wr_addr = base_wr_q + wr_cnt.
- State machine:
  - IDLE:
    - on start: latch base_rd, base_wr, mode; clear counters and the shift register; go to RUN.
    - start is ignored in every other state.
  - RUN: rd_ack = rd_adv. On accept:
    - rd_cnt++;
    - col += STEP_C;
    - if col+STEP_C >= IMG_W: col=0 and row_base += STEP_R;
    - if rd_cnt+1 == NOUT: go to DRAIN.
  - RUN/DRAIN write side: wr_ack = wr_adv && (wr_cnt < vld_cnt). On accept: wr_cnt++.
  - DRAIN:
    - rd_ack = 0.
    - When wr_cnt reaches NOUT (i.e. the cycle the last write is accepted): frame_done=1 for that next clock edge's cycle; state goes to IDLE the same edge.
  - frame_done is registered: high exactly one cycle after the final wr_ack.
- Simultaneous events:
  - rd_adv and wr_adv in the same cycle are both evaluated against the pre-edge counters.
  - The write gate uses vld_cnt before that cycle's read is counted.
- abort:
  - Highest priority in RUN/DRAIN: next state IDLE; no frame_done; counters frozen until the next start.
  - abort in IDLE is a no-op.
- Outside RUN/DRAIN: rd_ack = wr_ack = 0.
- rd_addr and wr_addr hold their last values in IDLE.
- Async rst mid-frame: immediate return to reset values; no frame_done.

Decomposition:
- Package img_seq_pkg holds:
  - state enum {S_IDLE, S_RUN, S_DRAIN};
  - mode constants MODE_LINEAR=1'b0, MODE_DECIM2=1'b1;
  - function nout(mode, w, h).
- One natural sub-module: img_lat_tracker, the RD_LAT shift register plus vld_cnt counter, parametrised by RD_LAT and count width.

Test Plan:
- Reset/idle: assert rst with rd_adv=wr_adv=1.
  - Outputs stay 0 and busy=0.
  - start with base_rd=0x100, base_wr=0x8000 gives rd_addr=0x100 and wr_addr=0x8000 the next cycle.
- Linear frame, IMG_W=4, IMG_H=2, RD_LAT=1, rd_adv held high, wr_adv=1 from cycle 0:
  - rd_addr sequence is 0x100..0x107;
  - first wr_ack occurs exactly one cycle after the first rd_ack;
  - frame_done pulses once, one cycle after the 8th wr_ack; busy drops with it.
- Decimation, IMG_W=4, IMG_H=4, mode=1, base_rd=0:
  - rd_addr sequence is 0,2,8,10;
  - exactly 4 writes are accepted;
  - a 5th wr_adv gets no ack.
- Interlock, RD_LAT=3: one rd_adv, then wr_adv held high.
  - wr_ack is 0 for the first 2 cycles and 1 in the 3rd cycle.
  - A second wr_adv with no further reads is refused.
- Abort in DRAIN, plus start ignored while busy:
  - start asserted while busy changes nothing;
  - abort returns to IDLE with no frame_done;
  - a new start restarts from the freshly latched bases.
- Address wrap: base_rd = 2^ADDR_W-2, linear frame.
  - rd_addr reads FFFF_FFFE, FFFF_FFFF, 0, 1, ... with no error.
